// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: configurable serial pattern scanner.
// A pattern of 2..MAXLEN bits is loaded through a ready/valid config port,
// then serial bits are compared against it and matches are pulsed and counted.
// Matches may overlap or not, and an optional limit parks the scanner in DONE.

module pattern_scan_ctrl #(
    parameter int  MAXLEN = 8,
    parameter int  CNTW   = 8,
    localparam int LENW   = $clog2(MAXLEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_limit,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    input  logic              din,
    input  logic              din_valid,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [MAXLEN-1:0]   r_pattern;
    logic [LENW-1:0]     r_len;
    logic                r_overlap;
    logic [CNTW-1:0]     r_limit;

    logic [MAXLEN-2:0]   r_history;
    logic [LENW-1:0]     r_fill;
    logic [CNTW-1:0]     r_count;

    logic                r_cfgReady;
    logic                r_cfgErr;
    logic                r_busy;
    logic                r_done;

    logic                w_lenLegal;
    logic                w_cfgOffer;
    logic                w_cfgAccept;
    logic                w_startScan;
    logic                w_shift;
    logic [MAXLEN-1:0]   w_window;
    logic [MAXLEN-1:0]   w_mask;
    logic                w_fillOk;
    logic                w_match;
    logic [CNTW-1:0]     w_countInc;
    logic                w_limitHit;

    assign w_lenLegal  = (cfg_len >= LENW'(2)) && (cfg_len <= LENW'(MAXLEN));
    assign w_cfgOffer  = cfg_valid && (r_state != SCAN);
    assign w_cfgAccept = w_cfgOffer && w_lenLegal;
    assign w_startScan = start && !cfg_valid && ((r_state == ARMED) || (r_state == DONE));
    assign w_shift     = (r_state == SCAN) && din_valid && !abort;
    assign w_window    = {r_history, din};
    assign w_fillOk    = ({1'b0, r_fill} + (LENW+1)'(1)) >= {1'b0, r_len};
    assign w_countInc  = (&r_count) ? r_count : r_count + CNTW'(1);
    assign w_limitHit  = (r_limit != '0) && (w_countInc == r_limit);

    // Build a mask selecting the low len bits of the comparison window
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // Mealy match: the incoming bit completes a window equal to the pattern
    always_comb begin
        w_match = w_shift && w_fillOk && (((w_window ^ r_pattern) & w_mask) == '0);
    end

    // Next-state selection; config takes precedence over start in the same cycle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, ARMED, DONE: begin
                if (w_cfgAccept) begin
                    w_nextState = ARMED;
                end else if (w_startScan) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    w_nextState = ARMED;
                end else if (w_match && w_limitHit) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cfgReady <= 1'b1;
            r_cfgErr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cfgReady <= (w_nextState != SCAN);
            r_cfgErr   <= w_cfgOffer && !w_lenLegal;
            r_busy     <= (w_nextState == SCAN);
            r_done     <= (w_nextState == DONE);
        end
    end

    // Config storage, history shift, fill tracking and match counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_limit   <= '0;
            r_history <= '0;
            r_fill    <= '0;
            r_count   <= '0;
        end else begin
            if (w_cfgAccept) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_limit   <= cfg_limit;
            end
            if (w_startScan) begin
                r_history <= '0;
                r_fill    <= '0;
                r_count   <= '0;
            end else if (w_shift) begin
                r_history <= w_window[MAXLEN-2:0];
                if (w_match && !r_overlap) begin
                    r_fill <= '0;
                end else if (r_fill != LENW'(MAXLEN)) begin
                    r_fill <= r_fill + LENW'(1);
                end
                if (w_match) begin
                    r_count <= w_countInc;
                end
            end
        end
    end

    assign cfg_ready   = r_cfgReady;
    assign cfg_err     = r_cfgErr;
    assign match       = w_match;
    assign match_count = r_count;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: self-checking bench for pattern_scan_ctrl.
// A behavioural model keeps the received bit stream in a queue and decides
// matches by comparing the most recent bits with the pattern directly.

module tb_pattern_scan_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;
    localparam int LENW   = $clog2(MAXLEN) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern = '0;
    logic [LENW-1:0]   cfg_len = '0;
    logic              cfg_overlap = 1'b0;
    logic [CNTW-1:0]   cfg_limit = '0;
    logic              cfg_err;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              din = 1'b0;
    logic              din_valid = 1'b0;
    logic              match;
    logic [CNTW-1:0]   match_count;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [MAXLEN-1:0] mPat;
    int                mLen;
    bit                mOvl;
    int                mLimit;
    bit                mScan;
    bit                mArmed;
    bit                mDone;
    int                mCount;
    int                mAvail;
    bit                mBits[$];

    pattern_scan_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a report
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void modelReset();
        mPat = '0; mLen = 0; mOvl = 0; mLimit = 0;
        mScan = 0; mArmed = 0; mDone = 0;
        mCount = 0; mAvail = 0;
        mBits.delete();
    endfunction

    // A match exists when enough fresh bits are available and the newest
    // len bits, newest first, equal pattern bits 0,1,2,...
    function automatic bit modelMatch(input bit b);
        bit s;
        if (mLen < 2) return 1'b0;
        if (mAvail + 1 < mLen) return 1'b0;
        for (int k = 0; k < mLen; k++) begin
            s = (k == 0) ? b : mBits[mBits.size() - k];
            if (s != mPat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One data cycle: drive at negedge, sample match, then update the model
    task automatic applyStimulus(input bit b, input bit v, input bit ab,
                                 output logic obsMatch, output logic expMatch);
        @(negedge clk);
        din = b; din_valid = v; abort = ab;
        #1;
        obsMatch = match;
        expMatch = mScan && v && !ab && modelMatch(b);
        @(posedge clk);
        #1;
        din_valid = 1'b0; abort = 1'b0;
        if (mScan && ab) begin
            mScan = 0; mArmed = 1;
        end else if (mScan && v) begin
            mBits.push_back(b);
            mAvail++;
            if (expMatch) begin
                if (mCount < 255) mCount++;
                if (!mOvl) mAvail = 0;
                if (mLimit != 0 && mCount == mLimit) begin
                    mScan = 0; mDone = 1;
                end
            end
        end
    endtask

    task automatic doConfig(input logic [MAXLEN-1:0] pat, input int len, input bit ovl,
                            input int lim, output logic obsErr);
        @(negedge clk);
        cfg_pattern = pat; cfg_len = LENW'(len); cfg_overlap = ovl;
        cfg_limit = CNTW'(lim); cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        obsErr = cfg_err;
        if (!mScan && len >= 2 && len <= MAXLEN) begin
            mPat = pat; mLen = len; mOvl = ovl; mLimit = lim;
            mArmed = 1; mDone = 0;
        end
    endtask

    task automatic doStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!mScan && (mArmed || mDone)) begin
            mScan = 1; mArmed = 0; mDone = 0;
            mCount = 0; mAvail = 0;
            mBits.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        checks++;
        if ({match, match_count, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got m=%b cnt=%0d busy=%b done=%b err=%b, expected all 0",
                     match, match_count, busy, done, cfg_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready);
        end
        doStart();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_start_ignored: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_overlap();
        logic om, em, err;
        logic [6:0] stream = 7'b1010101;
        logic [6:0] seen = '0;
        doConfig(8'b0000_1010, 4, 1'b1, 0, err);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovl_cfg_err: got %b expected 0", err);
        end
        doStart();
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovl_scan_entry: got busy=%b ready=%b expected 1/0", busy, cfg_ready);
        end
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
            seen[6-i] = om;
            checks++;
            if (om !== em) begin
                errors++;
                $display("[TB] FAIL ovl_match bit%0d: got %b expected %b", 7 - i, om, em);
            end
        end
        checks++;
        if (seen !== 7'b0101000) begin
            errors++;
            $display("[TB] FAIL ovl_positions: got %b expected 0101000", seen);
        end
        checks++;
        if (match_count !== CNTW'(2)) begin
            errors++;
            $display("[TB] FAIL ovl_count: got %0d expected 2", match_count);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, om, em);
    endtask

    task automatic test_no_overlap();
        logic om, em, err;
        logic [6:0] stream = 7'b1010101;
        logic [6:0] seen = '0;
        doConfig(8'b0000_1010, 4, 1'b0, 0, err);
        doStart();
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
            seen[6-i] = om;
            checks++;
            if (om !== em) begin
                errors++;
                $display("[TB] FAIL novl_match bit%0d: got %b expected %b", 7 - i, om, em);
            end
        end
        checks++;
        if (seen !== 7'b0001000 || match_count !== CNTW'(1)) begin
            errors++;
            $display("[TB] FAIL novl_result: got seen=%b cnt=%0d expected 0001000/1", seen, match_count);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, om, em);
    endtask

    task automatic test_limit();
        logic om, em, err;
        logic [5:0] stream = 6'b101010;
        doConfig(8'b0000_1010, 4, 1'b1, 2, err);
        doStart();
        for (int i = 5; i >= 0; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
            checks++;
            if (om !== em) begin
                errors++;
                $display("[TB] FAIL lim_match bit%0d: got %b expected %b", 6 - i, om, em);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || match_count !== CNTW'(2)) begin
            errors++;
            $display("[TB] FAIL lim_done: got done=%b busy=%b cnt=%0d expected 1/0/2", done, busy, match_count);
        end
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
            checks++;
            if (om !== 1'b0 || match_count !== CNTW'(2)) begin
                errors++;
                $display("[TB] FAIL lim_ignored: got m=%b cnt=%0d expected 0/2", om, match_count);
            end
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_ready: got %b expected 1", cfg_ready);
        end
        doConfig(8'b0000_0110, 4, 1'b0, 0, err);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || match_count !== CNTW'(2)) begin
            errors++;
            $display("[TB] FAIL done_recfg: got done=%b busy=%b cnt=%0d expected 0/0/2", done, busy, match_count);
        end
        doStart();
        checks++;
        if (match_count !== CNTW'(0) || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_clear: got cnt=%0d busy=%b expected 0/1", match_count, busy);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, om, em);
    endtask

    task automatic test_bad_cfg();
        logic om, em, err;
        int badLen[2] = '{0, MAXLEN + 1};
        logic [3:0] stream = 4'b0110;
        foreach (badLen[j]) begin
            doConfig(8'hFF, badLen[j], 1'b1, 1, err);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bad_cfg len=%0d: got err=%b busy=%b done=%b ready=%b expected 1/0/0/1",
                         badLen[j], err, busy, done, cfg_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (cfg_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bad_cfg_pulse len=%0d: got %b expected 0", badLen[j], cfg_err);
            end
        end
        doStart();
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
            checks++;
            if (om !== em) begin
                errors++;
                $display("[TB] FAIL bad_cfg_keep bit%0d: got %b expected %b", 4 - i, om, em);
            end
        end
        checks++;
        if (match_count !== CNTW'(1)) begin
            errors++;
            $display("[TB] FAIL bad_cfg_old_pattern: got cnt=%0d expected 1", match_count);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, om, em);
    endtask

    task automatic test_abort();
        logic om, em, err;
        logic [5:0] stream = 6'b101010;
        doConfig(8'b0000_1010, 4, 1'b1, 0, err);
        doStart();
        for (int i = 5; i >= 1; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
        end
        applyStimulus(stream[0], 1'b1, 1'b1, om, em);
        checks++;
        if (om !== 1'b0 || om !== em) begin
            errors++;
            $display("[TB] FAIL abort_match: got %b expected 0", om);
        end
        checks++;
        if (match_count !== CNTW'(1) || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_state: got cnt=%0d busy=%b ready=%b expected 1/0/1",
                     match_count, busy, cfg_ready);
        end
        doStart();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_to_armed: got busy=%b expected 1", busy);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, om, em);
    endtask

    task automatic test_random();
        logic om, em, err;
        for (int r = 0; r < 8; r++) begin
            doConfig(MAXLEN'($urandom), int'($urandom_range(2, MAXLEN)), 1'($urandom),
                     int'($urandom_range(0, 3)), err);
            doStart();
            for (int c = 0; c < 50; c++) begin
                applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0),
                              ($urandom_range(0, 39) == 0), om, em);
                checks++;
                if (om !== em || match_count !== CNTW'(mCount) || busy !== mScan || done !== mDone) begin
                    errors++;
                    $display("[TB] FAIL rand r%0d c%0d: got m=%b cnt=%0d busy=%b done=%b expected %b/%0d/%b/%b",
                             r, c, om, match_count, busy, done, em, mCount, mScan, mDone);
                end
            end
            applyStimulus(1'b0, 1'b0, 1'b1, om, em);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic om, em, err;
        logic [3:0] stream = 4'b1010;
        doConfig(8'b0000_1010, 4, 1'b1, 0, err);
        doStart();
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(stream[i], 1'b1, 1'b0, om, em);
        end
        checks++;
        if (match_count !== CNTW'(1) || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset: got cnt=%0d busy=%b expected 1/1", match_count, busy);
        end
        @(negedge clk);
        din = 1'b0; din_valid = 1'b1;
        #2 rst = 1'b1;
        modelReset();
        #1;
        checks++;
        if ({match, match_count, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("[TB] FAIL midscan_reset: got m=%b cnt=%0d busy=%b done=%b err=%b expected all 0",
                     match, match_count, busy, done, cfg_err);
        end
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: got ready=%b busy=%b expected 1/0", cfg_ready, busy);
        end
        doStart();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got busy=%b expected 0", busy);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_limit();
        test_bad_cfg();
        test_abort();
        test_random();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter MAXLEN, default 8, maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter CNTW, default 8, width of the match counter and the match limit.
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous, active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1 bit, configuration offer.
REQ-006 SHALL have port cfg_ready, output, 1 bit, configuration accept window.
REQ-007 SHALL have port cfg_pattern, input, MAXLEN bits, target pattern; bit [len-1] is the first serial bit and bit 0 is the last.
REQ-008 SHALL have port cfg_len, input, $clog2(MAXLEN)+1 bits, pattern length.
REQ-009 SHALL have port cfg_overlap, input, 1 bit: 1 allows overlapping matches, 0 does not.
REQ-010 SHALL have port cfg_limit, input, CNTW bits, number of matches to DONE; 0 means unlimited.
REQ-011 SHALL have port cfg_err, output, 1 bit, one-cycle pulse when a configuration is rejected.
REQ-012 SHALL have port start, input, 1 bit, begin a scan.
REQ-013 SHALL have port abort, input, 1 bit, end a scan.
REQ-014 SHALL have port din, input, 1 bit, serial data.
REQ-015 SHALL have port din_valid, input, 1 bit, din qualifier.
REQ-016 SHALL have port match, output, 1 bit, combinational Mealy pulse.
REQ-017 SHALL have port match_count, output, CNTW bits, registered count of matches.
REQ-018 SHALL have port busy, output, 1 bit, high in SCAN.
REQ-019 SHALL have port done, output, 1 bit, high in DONE.

Function
REQ-020 SHALL implement states IDLE, ARMED, SCAN and DONE, with one-hot or binary encoding at implementer choice.
REQ-021 SHALL drive cfg_ready=1 in IDLE, ARMED and DONE, and cfg_ready=0 in SCAN.
REQ-022 SHALL, on cfg_valid&&cfg_ready with 2<=cfg_len<=MAXLEN, register pattern, len, overlap and limit, then go to ARMED next cycle.
REQ-023 SHALL, on cfg_valid&&cfg_ready with an illegal cfg_len, pulse cfg_err for 1 cycle, keep the state and keep the prior config.
REQ-024 SHALL, on start in ARMED or DONE, go to SCAN and clear the history register, the fill counter and match_count; start SHALL be ignored in IDLE and SCAN.
REQ-025 SHALL, in SCAN on din_valid, shift history left by one bit with din entering at bit 0; the fill counter SHALL increment, saturating at MAXLEN.
REQ-026 SHALL compute match=1 in the same cycle when all of these hold: SCAN, din_valid, abort=0, fill>=len-1, and the low len bits of {history,din} equal the low len bits of the pattern.
REQ-027 SHALL, on match with overlap=0, reset fill to 0 so that no bit of a matched window is reused; with overlap=1, fill SHALL continue normally.
REQ-028 SHALL increment match_count by 1 on each match, saturating at all-ones.
REQ-029 SHALL, when limit!=0 and a match raises match_count to limit, go to DONE on the next edge; match_count SHALL then hold.
REQ-030 SHALL, on abort in SCAN, go to ARMED with priority over a same-cycle match; match SHALL be 0 and the count SHALL be unchanged.
REQ-031 SHALL ignore abort outside SCAN.
REQ-032 SHALL ignore din while din_valid=0, with no shift and no match.
REQ-033 SHALL, on accepting a new config in DONE, go to ARMED and retain match_count until the next start.

Reset
REQ-034 SHALL, on rst at any time including mid-scan, force IDLE and clear the stored config, history, fill, match_count, match, cfg_err, busy and done to 0.
REQ-035 SHALL have cfg_ready=1 in the first cycle after rst deasserts.

Verification
REQ-036 SHALL be verified with pattern=1010, len=4, overlap=1, limit=0, stream 1010101 -> match on bits 4 and 6, match_count=2.
REQ-037 SHALL be verified with the same stream and overlap=0 -> match on bit 4 only, match_count=1.
REQ-038 SHALL be verified with limit=2, overlap=1, stream 101010 -> match_count=2, done=1 from the cycle after bit 6, and later bits ignored.
REQ-039 SHALL be verified with cfg_len=0, and with cfg_len=MAXLEN+1 -> one cfg_err pulse each, state unchanged.
REQ-040 SHALL be verified with abort coincident with a matching bit -> match=0, match_count unchanged, ARMED next cycle.
REQ-041 SHALL be verified with rst asserted mid-SCAN after 1 match -> all outputs 0, IDLE, and cfg_ready=1 after release.
